dram_cmd_timing_ack: RTL and testbench
======================================

Name: dram_cmd_timing_ack

Overview:
- Downstream neighbour of dram_ctrl. Consumes its command handshake (cmd_req, cmd, bank_sel) and returns cmd_ack.
- Tracks per-bank open/closed state and enforces the JEDEC-style minimum spacings tRCD, tRP, tRAS, tWR and CAS latency before acknowledging.
- Replaces the fixed-delay ack model with a timing-accurate responder. It sits between the controller and the DRAM array model.

Parameters:
- NUM_OF_BANKS, 8, number of banks; width of bank_sel, one-hot.
- T_RCD, 3, minimum cycles from ACT issue to RD/WR issue, same bank.
- T_RP, 3, minimum cycles from PRE issue to ACT issue, same bank.
- T_RAS, 6, minimum cycles from ACT issue to PRE issue, same bank.
- T_WR, 2, minimum cycles from WR issue to PRE issue, same bank.
- T_CAS, 2, cycles from RD issue to cmd_ack rise.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cmd_req  in  1  4-phase request; held high until cmd_ack seen.
- cmd  in  2  command: 00 ACT, 01 RD, 10 WR, 11 PRE; stable while cmd_req high.
- bank_sel  in  NUM_OF_BANKS  one-hot target bank; stable while cmd_req high.
- cmd_ack  out  1  4-phase acknowledge, registered.
- cmd_err  out  1  valid while cmd_ack high; 1 = command rejected, no state change.
- cmd_issue  out  1  single-cycle pulse on the cycle a legal command takes effect.
- bank_open  out  NUM_OF_BANKS  per-bank row-open flags, registered.

Behaviour:
- Reset (async, rst_b low): cmd_ack=0, cmd_err=0, cmd_issue=0, bank_open=0. All timers 0, FSM in S_IDLE. Takes effect mid-handshake; any in-flight command is discarded.
- FSM states:
  - S_IDLE: wait for cmd_req=1.
  - S_WAIT: legal command, waiting for its timing constraint.
  - S_LAT: read issued, counting T_CAS.
  - S_ACK: cmd_ack=1, waiting for cmd_req=0.
- S_IDLE with cmd_req=1, legality check in that cycle:
  - Rejected if bank_sel is not one-hot (zero or multiple bits), RD/WR to a closed bank, or ACT to an open bank.
  - Rejected → S_ACK with cmd_err=1; cmd_issue stays 0; no state change.
  - PRE to a closed bank is a legal NOP: issues immediately with no timer load.
  - Otherwise → S_WAIT. If the constraint is already met, issue happens in the same cycle.
- Issue conditions for selected bank b; N = issue cycle of the earlier command:
  - ACT: ≥ N_pre+T_RP.
  - RD/WR: ≥ N_act+T_RCD.
  - PRE: ≥ N_act+T_RAS and ≥ N_wr+T_WR.
  - A bank with no history is unconstrained.
- On issue:
  - cmd_issue=1 for exactly one cycle.
  - ACT sets bank_open[b]; PRE clears it.
  - Per-bank timers load on issue. Implement them as saturating down-counters, width = clog2 of the largest parameter + 1.
- Ack timing:
  - ACT/WR/PRE: cmd_ack rises on the cycle after issue (→ S_ACK).
  - RD: → S_LAT, cmd_ack rises T_CAS cycles after the issue cycle.
- S_ACK: cmd_ack held until cmd_req is sampled 0, then cmd_ack=0 and cmd_err=0 next cycle → S_IDLE. A new cmd_req is accepted at the earliest one cycle after cmd_ack falls.
- cmd_req drops early:
  - In S_WAIT: command abandoned, no state change → S_IDLE.
  - In S_LAT: state already updated, no ack raised → S_IDLE.
- Timers of all banks count every cycle, independent of FSM state. Constraints are per bank only; no cross-bank constraints.
- cmd and bank_sel are sampled only in S_IDLE and held internally; changes while busy are ignored.

Decomposition:
- Shared package dram_pkg holds:
  - Command encoding constants CMD_ACT, CMD_RD, CMD_WR, CMD_PRE.
  - FSM state typedef.
  - Default timing constants, shared with dram_ctrl and dram_fsm.
- One sub-module, dram_bank_timer: one bank's open flag plus rcd/rp/ras/wr counters, with per-command "allowed" outputs. Instantiated NUM_OF_BANKS times via generate; the top holds the FSM and one-hot muxing.

Test Plan:
- Reset: rst_b=0 mid-S_LAT → cmd_ack, cmd_err, cmd_issue and bank_open all 0 immediately; after release, ACT to bank 0 acks normally.
- ACT bank 2 issued at cycle 10, then RD bank 2 requested at cycle 12 → RD cmd_issue at cycle 13 (10+T_RCD), cmd_ack rises at cycle 15.
- ACT bank 5 at cycle 20, then PRE bank 5 requested immediately → PRE issue at cycle 26 (T_RAS). bank_open[5] goes 1→0; the following ACT bank 5 issues no earlier than cycle 29 (T_RP).
- WR bank 1 issued at cycle 40 with T_RAS already satisfied, then PRE bank 1 → PRE issue at cycle 42 (T_WR).
- Illegal commands:
  - RD to closed bank 3 → cmd_ack=1, cmd_err=1, no cmd_issue, bank_open unchanged.
  - bank_sel=8'b0000_0110 → same error response.
- Early drop: cmd_req lowered while in S_WAIT for ACT → no cmd_issue, cmd_ack stays 0, FSM back in S_IDLE, bank stays closed.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: shared command encodings, responder FSM states and default DRAM timing constants
package dram_pkg;
  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;
  localparam int T_RCD_DEF = 3;
  localparam int T_RP_DEF  = 3;
  localparam int T_RAS_DEF = 6;
  localparam int T_WR_DEF  = 2;
  localparam int T_CAS_DEF = 2;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LAT, S_ACK} state_t;
  function automatic int tmr_w(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/dram_bank_timer.sv
// dram_bank_timer: one bank's row-open flag and rcd/rp/ras/wr saturating timers; in clk, rst_b, ld (issue strobe), cmd; out open, act_ok, rw_ok, pre_ok
module dram_bank_timer
  import dram_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RP  = T_RP_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int W     = tmr_w(T_RCD, T_RP, T_RAS, T_WR)
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       ld,
  input  logic [1:0] cmd,
  output logic       open,
  output logic       act_ok,
  output logic       rw_ok,
  output logic       pre_ok
);
  // Loaded with T-1 so a zero count in cycle c means an issue at c+1 meets the spacing.
  localparam logic [W-1:0] RCD_L = W'(T_RCD > 0 ? T_RCD - 1 : 0);
  localparam logic [W-1:0] RP_L  = W'(T_RP  > 0 ? T_RP  - 1 : 0);
  localparam logic [W-1:0] RAS_L = W'(T_RAS > 0 ? T_RAS - 1 : 0);
  localparam logic [W-1:0] WR_L  = W'(T_WR  > 0 ? T_WR  - 1 : 0);
  logic [W-1:0] rcd, rp, ras, wr;
  function automatic logic [W-1:0] dn(input logic [W-1:0] x);
    return x - W'(x != '0);
  endfunction
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      open <= 1'b0;
      rcd  <= '0;
      rp   <= '0;
      ras  <= '0;
      wr   <= '0;
    end else begin
      open <= ld && cmd == CMD_ACT ? 1'b1 : ld && cmd == CMD_PRE ? 1'b0 : open;
      rcd  <= ld && cmd == CMD_ACT ? RCD_L : dn(rcd);
      ras  <= ld && cmd == CMD_ACT ? RAS_L : dn(ras);
      rp   <= ld && cmd == CMD_PRE ? RP_L  : dn(rp);
      wr   <= ld && cmd == CMD_WR  ? WR_L  : dn(wr);
    end
  assign act_ok = rp == '0;
  assign rw_ok  = rcd == '0;
  assign pre_ok = !open || (ras == '0 && wr == '0);
endmodule

// File: rtl/dram_cmd_timing_ack.sv
// dram_cmd_timing_ack: timing-accurate 4-phase command responder; in clk, rst_b, cmd_req, cmd, bank_sel; out cmd_ack, cmd_err, cmd_issue, bank_open
module dram_cmd_timing_ack
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = 8,
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RP  = T_RP_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int T_CAS = T_CAS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic                    cmd_issue,
  output logic [NUM_OF_BANKS-1:0] bank_open
);
  localparam int W  = tmr_w(T_RCD, T_RP, T_RAS, T_WR);
  localparam int LW = $clog2(T_CAS > 1 ? T_CAS : 2);
  localparam logic [LW-1:0] LAT_L = LW'(T_CAS > 0 ? T_CAS - 1 : 0);
  state_t state;
  logic [1:0] cmd_q, c;
  logic [NUM_OF_BANKS-1:0] bank_q, b, act_ok, rw_ok, pre_ok, ld;
  logic [LW-1:0] lat;
  logic onehot, open_b, ok, legal, go;
  // Live inputs are only looked at in S_IDLE; afterwards the captured command drives everything.
  always_comb begin
    c      = state == S_IDLE ? cmd : cmd_q;
    b      = state == S_IDLE ? bank_sel : bank_q;
    onehot = b != '0 && (b & (b - NUM_OF_BANKS'(1))) == '0;
    open_b = |(b & bank_open);
    ok     = c == CMD_ACT ? |(b & act_ok) : c == CMD_PRE ? |(b & pre_ok) : |(b & rw_ok);
    legal  = onehot && (c == CMD_ACT ? !open_b : c == CMD_PRE ? 1'b1 : open_b);
    go     = cmd_req && ok && (state == S_IDLE ? legal : state == S_WAIT);
    ld     = go && !(c == CMD_PRE && !open_b) ? b : '0;
  end
  for (genvar i = 0; i < NUM_OF_BANKS; i++) begin : g_bank
    dram_bank_timer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR), .W(W)) u_tmr (
      .clk,
      .rst_b,
      .ld(ld[i]),
      .cmd(c),
      .open(bank_open[i]),
      .act_ok(act_ok[i]),
      .rw_ok(rw_ok[i]),
      .pre_ok(pre_ok[i])
    );
  end
  // S_ACK raises cmd_ack one cycle after entry, so non-read commands ack the cycle after issue.
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state     <= S_IDLE;
      cmd_q     <= CMD_ACT;
      bank_q    <= '0;
      lat       <= '0;
      cmd_ack   <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_issue <= 1'b0;
    end else begin
      cmd_issue <= go;
      case (state)
        S_IDLE:
          if (cmd_req) begin
            cmd_q  <= cmd;
            bank_q <= bank_sel;
            if (!legal) begin
              state   <= S_ACK;
              cmd_ack <= 1'b1;
              cmd_err <= 1'b1;
            end else if (go) begin
              state <= c == CMD_RD ? S_LAT : S_ACK;
              lat   <= LAT_L;
            end else
              state <= S_WAIT;
          end
        S_WAIT:
          if (!cmd_req)
            state <= S_IDLE;
          else if (go) begin
            state <= c == CMD_RD ? S_LAT : S_ACK;
            lat   <= LAT_L;
          end
        S_LAT:
          if (!cmd_req)
            state <= S_IDLE;
          else if (lat == '0) begin
            state   <= S_ACK;
            cmd_ack <= 1'b1;
          end else
            lat <= lat - LW'(1);
        S_ACK: begin
          cmd_ack <= cmd_req;
          if (!cmd_req) begin
            state   <= S_IDLE;
            cmd_err <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_cmd_timing_ack.sv
// tb_dram_cmd_timing_ack: scoreboard bench with a cycle-time reference model of bank timing
module tb_dram_cmd_timing_ack;
  localparam int NB = 8, T_RCD = 3, T_RP = 3, T_RAS = 6, T_WR = 2, T_CAS = 2;
  localparam logic [1:0] ACT = 2'd0, RD = 2'd1, WR = 2'd2, PRE = 2'd3;
  typedef struct {
    int issue;
    int ack;
    bit err;
    logic [NB-1:0] open;
  } exp_t;
  logic clk = 0, rst_b = 0, cmd_req = 0, cmd_ack, cmd_err, cmd_issue;
  logic [1:0] cmd = 0;
  logic [NB-1:0] bank_sel = 0, bank_open;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_issue = 0, last_issue = -1;
  logic ack_d = 0;
  exp_t exp_q[$];
  exp_t me;
  bit [NB-1:0] mopen;
  int t_act[NB], t_pre[NB], t_wr[NB];

  dram_cmd_timing_ack #(.NUM_OF_BANKS(NB)) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd), .bank_sel(bank_sel),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .cmd_issue(cmd_issue), .bank_open(bank_open)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic int max2(input int a, input int b2);
    return a > b2 ? a : b2;
  endfunction

  function automatic void model_reset();
    mopen = '0;
    for (int i = 0; i < NB; i++) begin
      t_act[i] = -1000;
      t_pre[i] = -1000;
      t_wr[i]  = -1000;
    end
  endfunction

  always @(negedge clk) begin
    if (cmd_issue) begin
      last_issue = cyc;
      n_issue++;
    end
    if (cmd_ack && !ack_d) begin
      if (exp_q.size() == 0) chk("ack_without_request", exp_q.size(), 1);
      else begin
        me = exp_q.pop_front();
        chk("ack_cycle", cyc, me.ack);
        chk("ack_err", cmd_err, me.err);
        chk("issue_cycle", last_issue, me.issue);
        chk("bank_open", bank_open, me.open);
        last_issue = -1;
      end
    end
    ack_d = cmd_ack;
  end

  task automatic send(input logic [1:0] c, input logic [NB-1:0] bs, input int gap);
    exp_t e;
    int b, k, t;
    repeat (gap) @(posedge clk);
    #1;
    k = cyc;
    b = 0;
    for (int i = 0; i < NB; i++) if (bs[i]) b = i;
    e.err = $countones(bs) != 1 || (c inside {RD, WR} && !mopen[b]) || (c == ACT && mopen[b]);
    e.issue = -1;
    e.ack = k + 1;
    if (!e.err) begin
      e.issue = k + 1;
      if (c == ACT) begin
        e.issue = max2(e.issue, t_pre[b] + T_RP);
        t_act[b] = e.issue;
        mopen[b] = 1'b1;
      end else if (c == PRE) begin
        if (mopen[b]) begin
          e.issue = max2(max2(e.issue, t_act[b] + T_RAS), t_wr[b] + T_WR);
          t_pre[b] = e.issue;
          mopen[b] = 1'b0;
        end
      end else begin
        e.issue = max2(e.issue, t_act[b] + T_RCD);
        if (c == WR) t_wr[b] = e.issue;
      end
      e.ack = e.issue + (c == RD ? T_CAS : 1);
    end
    e.open = mopen;
    exp_q.push_back(e);
    cmd = c;
    bank_sel = bs;
    cmd_req = 1;
    t = 0;
    while (!cmd_ack && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ack) begin
      chk("ack_timeout", cmd_ack, 1);
      exp_q.delete();
    end
    cmd_req = 0;
    cmd = 2'($urandom);
    bank_sel = NB'($urandom);
    t = 0;
    while (cmd_ack && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    if (cmd_ack) chk("ack_release_timeout", cmd_ack, 0);
    @(posedge clk); #1;
  endtask

  task automatic drop_test(input logic [1:0] c, input logic [NB-1:0] bs);
    int n0;
    logic seen;
    n0 = n_issue;
    seen = 0;
    cmd = c;
    bank_sel = bs;
    cmd_req = 1;
    @(posedge clk); #1;
    cmd_req = 0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= cmd_ack;
    end
    chk("drop_ack", seen, 0);
    chk("drop_issue", n_issue, n0);
    chk("drop_open", bank_open, mopen);
  endtask

  initial begin
    int t;
    logic [1:0] c;
    logic [NB-1:0] bs;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", cmd_ack, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_issue", cmd_issue, 0);
    chk("rst_open", bank_open, 0);
    rst_b = 1;
    @(posedge clk); #1;
    send(ACT, 8'h04, 0);
    send(RD,  8'h04, 0);
    send(ACT, 8'h20, 2);
    send(PRE, 8'h20, 0);
    send(ACT, 8'h20, 0);
    send(ACT, 8'h02, 0);
    send(WR,  8'h02, 6);
    send(PRE, 8'h02, 0);
    send(RD,  8'h08, 0);
    send(WR,  8'h08, 1);
    send(ACT, 8'h06, 0);
    send(PRE, 8'h00, 2);
    send(ACT, 8'h20, 0);
    send(PRE, 8'h80, 0);
    send(ACT, 8'h40, 0);
    drop_test(PRE, 8'h40);
    send(PRE, 8'h40, 0);
    send(ACT, 8'h08, 0);
    cmd = RD;
    bank_sel = 8'h08;
    cmd_req = 1;
    t = 0;
    while (!cmd_issue && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rd_issue_before_reset", cmd_issue, 1);
    rst_b = 0;
    #1;
    chk("midrst_ack", cmd_ack, 0);
    chk("midrst_err", cmd_err, 0);
    chk("midrst_issue", cmd_issue, 0);
    chk("midrst_open", bank_open, 0);
    model_reset();
    cmd_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1;
    @(posedge clk); #1;
    send(ACT, 8'h01, 0);
    send(RD,  8'h01, 0);
    for (int n = 0; n < 300; n++) begin
      c = 2'($urandom_range(0, 3));
      bs = $urandom_range(0, 9) == 0 ? NB'($urandom) : NB'(1) << $urandom_range(0, 3);
      send(c, bs, $urandom_range(0, 3));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("pending_expect", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
